// File: rtl/dtw_regbank_pkg.sv
// Shared constants, index classes and address helpers for the DTW AXI4-Lite register bank.
package dtw_regbank_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [2:0] {
      CTRL,
      STAT,
      IRQ_STS,
      IRQ_EN,
      UNMAPPED
   } idx_class_e;

   // Byte-address bits below the word index: 2 for a 32-bit bus, 3 for 64-bit.
   function automatic int addr_lsb(input int data_width);
      return data_width / 32 + 1;
   endfunction

   function automatic idx_class_e decode_idx(input int idx, input int num_ctrl,
                                             input int num_stat, input bit irq_build);
      if (idx < num_ctrl)
         return CTRL;
      else if (idx < num_ctrl + num_stat)
         return STAT;
      else if (irq_build && idx == num_ctrl + num_stat)
         return IRQ_STS;
      else if (irq_build && idx == num_ctrl + num_stat + 1)
         return IRQ_EN;
      else
         return UNMAPPED;
   endfunction

endpackage

// File: rtl/dtw_axil_hold.sv
// One-entry hold register for an AXI4-Lite request channel (AW address or W data+strobe).
module dtw_axil_hold #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             held,
   output logic [WIDTH-1:0] held_data,
   input  logic             pop
);

   // pop is only raised while held, so it never coincides with an accept.
   assign in_ready = ~held;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         held      <= 1'b0;
         held_data <= '0;
      end else if (pop) begin
         held <= 1'b0;
      end else if (in_valid && in_ready) begin
         held      <= 1'b1;
         held_data <= in_data;
      end
   end

endmodule

// File: rtl/dtw_axil_regbank.sv
// Parametrised AXI4-Lite control/status register bank for the DTW accelerator.
// Define DTW_REGBANK_IRQ_EN to build the sticky W1C interrupt status/enable block and irq output.
module dtw_axil_regbank
   import dtw_regbank_pkg::*;
#(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 6,
   parameter int NUM_CTRL           = 4,
   parameter int NUM_STAT           = 4,
   parameter int NUM_IRQ            = 4,
   parameter logic [NUM_CTRL*C_S_AXI_DATA_WIDTH-1:0] CTRL_RST_VAL =
      (NUM_CTRL*C_S_AXI_DATA_WIDTH)'(29898) << (2*C_S_AXI_DATA_WIDTH)
) (
   input  logic                                   S_AXI_ACLK,
   input  logic                                   S_AXI_ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
   input  logic [2:0]                             S_AXI_AWPROT,
   input  logic                                   S_AXI_AWVALID,
   output logic                                   S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
   input  logic                                   S_AXI_WVALID,
   output logic                                   S_AXI_WREADY,
   output logic [1:0]                             S_AXI_BRESP,
   output logic                                   S_AXI_BVALID,
   input  logic                                   S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
   input  logic [2:0]                             S_AXI_ARPROT,
   input  logic                                   S_AXI_ARVALID,
   output logic                                   S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
   output logic [1:0]                             S_AXI_RRESP,
   output logic                                   S_AXI_RVALID,
   input  logic                                   S_AXI_RREADY,
   output logic [NUM_CTRL*C_S_AXI_DATA_WIDTH-1:0] ctrl_regs,
   input  logic [NUM_STAT*C_S_AXI_DATA_WIDTH-1:0] stat_regs,
   input  logic [NUM_IRQ-1:0]                     irq_event,
   output logic                                   irq
);

   localparam int DW  = C_S_AXI_DATA_WIDTH;
   localparam int SW  = DW / 8;
   localparam int LSB = addr_lsb(DW);
   localparam int IW  = C_S_AXI_ADDR_WIDTH - LSB;
`ifdef DTW_REGBANK_IRQ_EN
   localparam bit IRQ_BUILD = 1'b1;
`else
   localparam bit IRQ_BUILD = 1'b0;
`endif

   // Handshakes: a transfer happens on a rising edge where VALID and READY are both high;
   // VALID never depends on READY, and a raised B/R VALID stays up until its READY is seen.

   logic                          aw_held;
   logic [C_S_AXI_ADDR_WIDTH-1:0] aw_addr;
   logic                          w_held;
   logic [SW+DW-1:0]              w_bundle;
   logic                          commit;

   dtw_axil_hold #(.WIDTH(C_S_AXI_ADDR_WIDTH)) u_aw_hold (
      .clk       (S_AXI_ACLK),
      .rst_n     (S_AXI_ARESETN),
      .in_valid  (S_AXI_AWVALID),
      .in_ready  (S_AXI_AWREADY),
      .in_data   (S_AXI_AWADDR),
      .held      (aw_held),
      .held_data (aw_addr),
      .pop       (commit)
   );

   dtw_axil_hold #(.WIDTH(SW+DW)) u_w_hold (
      .clk       (S_AXI_ACLK),
      .rst_n     (S_AXI_ARESETN),
      .in_valid  (S_AXI_WVALID),
      .in_ready  (S_AXI_WREADY),
      .in_data   ({S_AXI_WSTRB, S_AXI_WDATA}),
      .held      (w_held),
      .held_data (w_bundle),
      .pop       (commit)
   );

   logic [SW-1:0] w_strb;
   logic [DW-1:0] w_data;
   logic [DW-1:0] byte_mask;
   logic [DW-1:0] wm;
   logic [IW-1:0] w_idx;
   logic [IW-1:0] r_idx;
   idx_class_e    w_cls;
   idx_class_e    r_cls;

   assign w_strb = w_bundle[SW+DW-1:DW];
   assign w_data = w_bundle[DW-1:0];
   assign w_idx  = aw_addr[C_S_AXI_ADDR_WIDTH-1:LSB];
   assign r_idx  = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:LSB];
   assign w_cls  = decode_idx(int'(w_idx), NUM_CTRL, NUM_STAT, IRQ_BUILD);
   assign r_cls  = decode_idx(int'(r_idx), NUM_CTRL, NUM_STAT, IRQ_BUILD);

   // A new write waits for the previous response to drain so B never needs a queue.
   assign commit = aw_held & w_held & ~S_AXI_BVALID;

   always_comb begin
      byte_mask = '0;
      for (int b = 0; b < SW; b++)
         byte_mask[b*8 +: 8] = {8{w_strb[b]}};
   end

   assign wm = w_data & byte_mask;

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         S_AXI_BVALID <= 1'b0;
         S_AXI_BRESP  <= RESP_OKAY;
      end else if (commit) begin
         S_AXI_BVALID <= 1'b1;
         S_AXI_BRESP  <= (w_cls == UNMAPPED) ? RESP_SLVERR : RESP_OKAY;
      end else if (S_AXI_BVALID && S_AXI_BREADY) begin
         S_AXI_BVALID <= 1'b0;
      end
   end

   logic [NUM_CTRL*DW-1:0] ctrl_q;

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         ctrl_q <= CTRL_RST_VAL;
      end else if (commit && w_cls == CTRL) begin
         for (int i = 0; i < NUM_CTRL; i++)
            if (int'(w_idx) == i)
               ctrl_q[i*DW +: DW] <= (ctrl_q[i*DW +: DW] & ~byte_mask) | wm;
      end
   end

   assign ctrl_regs = ctrl_q;

   // Status is retimed once so the read mux never sees the core's raw combinational outputs.
   logic [NUM_STAT*DW-1:0] stat_q;

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN)
         stat_q <= '0;
      else
         stat_q <= stat_regs;
   end

   logic [DW-1:0] irq_sts_word;
   logic [DW-1:0] irq_en_word;

`ifdef DTW_REGBANK_IRQ_EN
   logic [NUM_IRQ-1:0] irq_sts_q;
   logic [NUM_IRQ-1:0] irq_en_q;
   logic [NUM_IRQ-1:0] irq_clr;
   logic               irq_q;

   assign irq_clr = (commit && w_cls == IRQ_STS) ? wm[NUM_IRQ-1:0] : '0;

   // OR-ing events in after the clear lets a fresh event win over a same-cycle W1C.
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         irq_sts_q <= '0;
         irq_en_q  <= '0;
         irq_q     <= 1'b0;
      end else begin
         irq_sts_q <= (irq_sts_q & ~irq_clr) | irq_event;
         if (commit && w_cls == IRQ_EN)
            irq_en_q <= (irq_en_q & ~byte_mask[NUM_IRQ-1:0]) | wm[NUM_IRQ-1:0];
         irq_q <= |(irq_sts_q & irq_en_q);
      end
   end

   always_comb begin
      irq_sts_word = '0;
      irq_en_word  = '0;
      irq_sts_word[NUM_IRQ-1:0] = irq_sts_q;
      irq_en_word[NUM_IRQ-1:0]  = irq_en_q;
   end

   assign irq = irq_q;
`else
   logic unused_irq_event;

   assign unused_irq_event = ^irq_event;
   assign irq_sts_word     = '0;
   assign irq_en_word      = '0;
   assign irq              = 1'b0;
`endif

   logic [DW-1:0] rd_data;
   logic [1:0]    rd_resp;

   always_comb begin
      rd_data = '0;
      rd_resp = RESP_OKAY;
      case (r_cls)
         CTRL: begin
            for (int i = 0; i < NUM_CTRL; i++)
               if (int'(r_idx) == i)
                  rd_data = ctrl_q[i*DW +: DW];
         end
         STAT: begin
            for (int i = 0; i < NUM_STAT; i++)
               if (int'(r_idx) == NUM_CTRL + i)
                  rd_data = stat_q[i*DW +: DW];
         end
         IRQ_STS: rd_data = irq_sts_word;
         IRQ_EN:  rd_data = irq_en_word;
         default: rd_resp = RESP_SLVERR;
      endcase
   end

   assign S_AXI_ARREADY = ~S_AXI_RVALID;

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         S_AXI_RVALID <= 1'b0;
         S_AXI_RDATA  <= '0;
         S_AXI_RRESP  <= RESP_OKAY;
      end else if (S_AXI_ARVALID && S_AXI_ARREADY) begin
         S_AXI_RVALID <= 1'b1;
         S_AXI_RDATA  <= rd_data;
         S_AXI_RRESP  <= rd_resp;
      end else if (S_AXI_RVALID && S_AXI_RREADY) begin
         S_AXI_RVALID <= 1'b0;
      end
   end

   logic unused_addr_bits;

   assign unused_addr_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                               aw_addr[LSB-1:0], S_AXI_ARADDR[LSB-1:0]};

endmodule

// File: tb/tb_dtw_axil_regbank.sv
// Self-checking bench for dtw_axil_regbank; adapts to DTW_REGBANK_IRQ_EN when defined.
module tb_dtw_axil_regbank;

   localparam int DW = 32;
   localparam int AW = 6;
   localparam int NC = 4;
   localparam int NS = 4;
   localparam int NI = 4;
   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;

   logic              S_AXI_ACLK = 1'b0;
   logic              S_AXI_ARESETN;
   logic [AW-1:0]     S_AXI_AWADDR;
   logic [2:0]        S_AXI_AWPROT;
   logic              S_AXI_AWVALID;
   logic              S_AXI_AWREADY;
   logic [DW-1:0]     S_AXI_WDATA;
   logic [DW/8-1:0]   S_AXI_WSTRB;
   logic              S_AXI_WVALID;
   logic              S_AXI_WREADY;
   logic [1:0]        S_AXI_BRESP;
   logic              S_AXI_BVALID;
   logic              S_AXI_BREADY;
   logic [AW-1:0]     S_AXI_ARADDR;
   logic [2:0]        S_AXI_ARPROT;
   logic              S_AXI_ARVALID;
   logic              S_AXI_ARREADY;
   logic [DW-1:0]     S_AXI_RDATA;
   logic [1:0]        S_AXI_RRESP;
   logic              S_AXI_RVALID;
   logic              S_AXI_RREADY;
   logic [NC*DW-1:0]  ctrl_regs;
   logic [NS*DW-1:0]  stat_regs;
   logic [NI-1:0]     irq_event;
   logic              irq;

   dtw_axil_regbank dut (
      .S_AXI_ACLK    (S_AXI_ACLK),
      .S_AXI_ARESETN (S_AXI_ARESETN),
      .S_AXI_AWADDR  (S_AXI_AWADDR),
      .S_AXI_AWPROT  (S_AXI_AWPROT),
      .S_AXI_AWVALID (S_AXI_AWVALID),
      .S_AXI_AWREADY (S_AXI_AWREADY),
      .S_AXI_WDATA   (S_AXI_WDATA),
      .S_AXI_WSTRB   (S_AXI_WSTRB),
      .S_AXI_WVALID  (S_AXI_WVALID),
      .S_AXI_WREADY  (S_AXI_WREADY),
      .S_AXI_BRESP   (S_AXI_BRESP),
      .S_AXI_BVALID  (S_AXI_BVALID),
      .S_AXI_BREADY  (S_AXI_BREADY),
      .S_AXI_ARADDR  (S_AXI_ARADDR),
      .S_AXI_ARPROT  (S_AXI_ARPROT),
      .S_AXI_ARVALID (S_AXI_ARVALID),
      .S_AXI_ARREADY (S_AXI_ARREADY),
      .S_AXI_RDATA   (S_AXI_RDATA),
      .S_AXI_RRESP   (S_AXI_RRESP),
      .S_AXI_RVALID  (S_AXI_RVALID),
      .S_AXI_RREADY  (S_AXI_RREADY),
      .ctrl_regs     (ctrl_regs),
      .stat_regs     (stat_regs),
      .irq_event     (irq_event),
      .irq           (irq)
   );

   // clock / reset
   always #5 S_AXI_ACLK = ~S_AXI_ACLK;

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   // scoreboard state
   int          n_compared   = 0;
   int          n_mismatched = 0;
   logic [1:0]  exp_b_q[$];
   logic [33:0] exp_r_q[$];
   logic [1:0]  b_exp;
   logic [33:0] r_exp;

   logic [31:0] ctrl_m [NC];
   logic [31:0] stat_m [NS];
   logic [NI-1:0] sts_m;
   logic [NI-1:0] en_m;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_compared++;
      if (got !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // 0 ctrl, 1 stat, 2 irq status, 3 irq enable, 4 unmapped
   function automatic int cls_of(input int idx);
      if (idx < NC) return 0;
      if (idx < NC + NS) return 1;
`ifdef DTW_REGBANK_IRQ_EN
      if (idx == NC + NS) return 2;
      if (idx == NC + NS + 1) return 3;
`endif
      return 4;
   endfunction

   function automatic logic [31:0] strb_mask(input logic [3:0] s);
      logic [31:0] m;
      for (int b = 0; b < 4; b++) m[b*8 +: 8] = {8{s[b]}};
      return m;
   endfunction

   function automatic logic [1:0] exp_bresp(input int idx);
      return (cls_of(idx) == 4) ? SLVERR : OKAY;
   endfunction

   function automatic logic [33:0] exp_read(input int idx);
      logic [31:0] d;
      d = '0;
      case (cls_of(idx))
         0: return {OKAY, ctrl_m[idx]};
         1: return {OKAY, stat_m[idx-NC]};
         2: begin d[NI-1:0] = sts_m; return {OKAY, d}; end
         3: begin d[NI-1:0] = en_m;  return {OKAY, d}; end
         default: return {SLVERR, 32'h0};
      endcase
   endfunction

   task automatic model_write(input int idx, input logic [31:0] data, input logic [3:0] strb);
      logic [31:0] m;
      m = strb_mask(strb);
      case (cls_of(idx))
         0: ctrl_m[idx] = (ctrl_m[idx] & ~m) | (data & m);
         2: sts_m = sts_m & ~(data[NI-1:0] & m[NI-1:0]);
         3: en_m  = (en_m & ~m[NI-1:0]) | (data[NI-1:0] & m[NI-1:0]);
         default: ;
      endcase
   endtask

   task automatic model_reset();
      ctrl_m[0] = 32'd0;
      ctrl_m[1] = 32'd0;
      ctrl_m[2] = 32'd29898;
      ctrl_m[3] = 32'd0;
      sts_m = '0;
      en_m  = '0;
   endtask

   // monitor: pop and compare when the DUT completes a response handshake
   always @(negedge S_AXI_ACLK) begin
      if (S_AXI_ARESETN && S_AXI_BVALID && S_AXI_BREADY) begin
         if (exp_b_q.size() == 0) begin
            check_val("b_unexpected", 64'd1, 64'd0);
         end else begin
            b_exp = exp_b_q.pop_front();
            check_val("bresp", 64'(S_AXI_BRESP), 64'(b_exp));
         end
      end
      if (S_AXI_ARESETN && S_AXI_RVALID && S_AXI_RREADY) begin
         if (exp_r_q.size() == 0) begin
            check_val("r_unexpected", 64'd1, 64'd0);
         end else begin
            r_exp = exp_r_q.pop_front();
            check_val("rdata", 64'(S_AXI_RDATA), 64'(r_exp[31:0]));
            check_val("rresp", 64'(S_AXI_RRESP), 64'(r_exp[33:32]));
         end
      end
   end

   // driver tasks
   task automatic tick();
      @(posedge S_AXI_ACLK);
      #1;
   endtask

   task automatic drive_stat();
      for (int i = 0; i < NS; i++) stat_regs[i*32 +: 32] = stat_m[i];
   endtask

   task automatic drive_aw_w(input int idx, input logic [31:0] data, input logic [3:0] strb);
      check_val("aw_w_ready_pre", 64'({S_AXI_AWREADY, S_AXI_WREADY}), 64'd3);
      S_AXI_AWADDR  = AW'(idx * 4);
      S_AXI_AWVALID = 1'b1;
      S_AXI_WDATA   = data;
      S_AXI_WSTRB   = strb;
      S_AXI_WVALID  = 1'b1;
      tick();
      S_AXI_AWVALID = 1'b0;
      S_AXI_WVALID  = 1'b0;
   endtask

   task automatic axi_write(input int idx, input logic [31:0] data, input logic [3:0] strb);
      int n;
      S_AXI_BREADY = 1'b1;
      exp_b_q.push_back(exp_bresp(idx));
      drive_aw_w(idx, data, strb);
      model_write(idx, data, strb);
      n = 0;
      while (!S_AXI_BVALID && n < 20) begin tick(); n++; end
      if (!S_AXI_BVALID) check_val("b_timeout", 64'd0, 64'd1);
      tick();
   endtask

   task automatic axi_read(input int idx);
      int n;
      S_AXI_RREADY = 1'b1;
      exp_r_q.push_back(exp_read(idx));
      check_val("arready_pre", 64'(S_AXI_ARREADY), 64'd1);
      S_AXI_ARADDR  = AW'(idx * 4);
      S_AXI_ARVALID = 1'b1;
      tick();
      S_AXI_ARVALID = 1'b0;
      check_val("rvalid_latency", 64'(S_AXI_RVALID), 64'd1);
      n = 0;
      while (!S_AXI_RVALID && n < 20) begin tick(); n++; end
      tick();
   endtask

   task automatic check_reset_outputs(input string tag);
      check_val({tag, "_awready"}, 64'(S_AXI_AWREADY), 64'd1);
      check_val({tag, "_wready"},  64'(S_AXI_WREADY),  64'd1);
      check_val({tag, "_arready"}, 64'(S_AXI_ARREADY), 64'd1);
      check_val({tag, "_bvalid"},  64'(S_AXI_BVALID),  64'd0);
      check_val({tag, "_rvalid"},  64'(S_AXI_RVALID),  64'd0);
      check_val({tag, "_bresp"},   64'(S_AXI_BRESP),   64'(OKAY));
      check_val({tag, "_rresp"},   64'(S_AXI_RRESP),   64'(OKAY));
      check_val({tag, "_rdata"},   64'(S_AXI_RDATA),   64'd0);
      check_val({tag, "_irq"},     64'(irq),           64'd0);
      for (int i = 0; i < NC; i++)
         check_val({tag, "_ctrl"}, 64'(ctrl_regs[i*32 +: 32]), 64'(ctrl_m[i]));
   endtask

   // stimulus
   initial begin
      S_AXI_ARESETN = 1'b0;
      S_AXI_AWADDR  = '0;
      S_AXI_AWPROT  = '0;
      S_AXI_AWVALID = 1'b0;
      S_AXI_WDATA   = '0;
      S_AXI_WSTRB   = '0;
      S_AXI_WVALID  = 1'b0;
      S_AXI_BREADY  = 1'b1;
      S_AXI_ARADDR  = '0;
      S_AXI_ARPROT  = '0;
      S_AXI_ARVALID = 1'b0;
      S_AXI_RREADY  = 1'b1;
      irq_event     = '0;
      model_reset();
      for (int i = 0; i < NS; i++) stat_m[i] = $urandom;
      stat_m[1] = 32'hDEAD_BEEF;
      drive_stat();

      repeat (3) tick();
      check_reset_outputs("reset");
      S_AXI_ARESETN = 1'b1;
      tick();

      // reset value of ctrl index 2
      axi_read(2);
      check_val("ctrl2_port", 64'(ctrl_regs[95:64]), 64'd29898);

      // AW first, W three cycles later, single-byte strobe
      axi_write(0, 32'h1122_3344, 4'hF);
      exp_b_q.push_back(OKAY);
      S_AXI_AWADDR  = AW'(0);
      S_AXI_AWVALID = 1'b1;
      tick();
      S_AXI_AWVALID = 1'b0;
      check_val("aw_held_ready", 64'(S_AXI_AWREADY), 64'd0);
      tick();
      tick();
      S_AXI_WDATA  = 32'hA5A5_0001;
      S_AXI_WSTRB  = 4'b0001;
      S_AXI_WVALID = 1'b1;
      tick();
      S_AXI_WVALID = 1'b0;
      check_val("b_not_early", 64'(S_AXI_BVALID), 64'd0);
      check_val("ctrl0_pre", 64'(ctrl_regs[31:0]), 64'h1122_3344);
      model_write(0, 32'hA5A5_0001, 4'b0001);
      tick();
      check_val("b_after_w", 64'(S_AXI_BVALID), 64'd1);
      check_val("ctrl0_merge", 64'(ctrl_regs[31:0]), 64'(ctrl_m[0]));
      tick();

      // RO and unmapped targets
      axi_write(5, 32'h1234_5678, 4'hF);
      axi_write(15, 32'h1234_5678, 4'hF);
      axi_read(5);
      axi_read(15);

      // read with RREADY withheld
      exp_r_q.push_back(exp_read(NC + 1));
      S_AXI_RREADY  = 1'b0;
      S_AXI_ARADDR  = AW'((NC + 1) * 4);
      S_AXI_ARVALID = 1'b1;
      tick();
      S_AXI_ARVALID = 1'b0;
      check_val("rvalid_1cyc", 64'(S_AXI_RVALID), 64'd1);
      for (int i = 0; i < 4; i++) begin
         check_val("rvalid_stall", 64'(S_AXI_RVALID), 64'd1);
         check_val("rdata_stall",  64'(S_AXI_RDATA),  64'hDEAD_BEEF);
         check_val("arready_stall", 64'(S_AXI_ARREADY), 64'd0);
         tick();
      end
      S_AXI_RREADY = 1'b1;
      tick();
      check_val("rvalid_drop", 64'(S_AXI_RVALID), 64'd0);

      // random traffic across the whole index space
      for (int k = 0; k < 16; k++) begin
         int idx;
         idx = $urandom_range(0, 15);
         axi_write(idx, $urandom, 4'($urandom_range(0, 15)));
         axi_read(idx);
         if (k % 4 == 0) begin
            stat_m[k % NS] = $urandom;
            drive_stat();
            tick();
            axi_read(NC + k % NS);
         end
      end

`ifdef DTW_REGBANK_IRQ_EN
      axi_write(NC + NS, 32'hFFFF_FFFF, 4'hF);
      axi_write(NC + NS + 1, 32'h0000_0001, 4'hF);
      tick();
      check_val("irq_idle", 64'(irq), 64'd0);
      irq_event = 4'b0001;
      tick();
      irq_event = '0;
      sts_m[0] = 1'b1;
      check_val("irq_not_yet", 64'(irq), 64'd0);
      tick();
      check_val("irq_assert", 64'(irq), 64'd1);

      // W1C racing a new event: the event wins
      exp_b_q.push_back(OKAY);
      drive_aw_w(NC + NS, 32'h1, 4'hF);
      irq_event = 4'b0001;
      tick();
      irq_event = '0;
      tick();
      axi_read(NC + NS);
      check_val("irq_set_wins", 64'(irq), 64'd1);

      // read landing on the W1C commit edge sees the pre-clear value
      exp_b_q.push_back(OKAY);
      drive_aw_w(NC + NS, 32'h1, 4'hF);
      exp_r_q.push_back(exp_read(NC + NS));
      S_AXI_ARADDR  = AW'((NC + NS) * 4);
      S_AXI_ARVALID = 1'b1;
      model_write(NC + NS, 32'h1, 4'hF);
      tick();
      S_AXI_ARVALID = 1'b0;
      check_val("irq_hold", 64'(irq), 64'd1);
      tick();
      check_val("irq_clear", 64'(irq), 64'd0);
      axi_read(NC + NS);
`else
      axi_read(NC + NS);
      axi_read(NC + NS + 1);
      axi_write(NC + NS + 1, 32'hF, 4'hF);
      irq_event = '1;
      tick();
      irq_event = '0;
      tick();
      tick();
      check_val("irq_tied", 64'(irq), 64'd0);
`endif

      // second write held behind an unaccepted response
      S_AXI_BREADY = 1'b0;
      exp_b_q.push_back(OKAY);
      exp_b_q.push_back(OKAY);
      drive_aw_w(1, 32'hCAFE_0001, 4'hF);
      model_write(1, 32'hCAFE_0001, 4'hF);
      tick();
      check_val("b1_valid", 64'(S_AXI_BVALID), 64'd1);
      drive_aw_w(3, 32'h0BAD_F00D, 4'hF);
      check_val("aw_blocked", 64'(S_AXI_AWREADY), 64'd0);
      check_val("w_blocked",  64'(S_AXI_WREADY),  64'd0);
      tick();
      tick();
      check_val("ctrl3_waits", 64'(ctrl_regs[127:96]), 64'(ctrl_m[3]));
      S_AXI_BREADY = 1'b1;
      tick();
      check_val("b1_cleared", 64'(S_AXI_BVALID), 64'd0);
      check_val("ctrl3_still", 64'(ctrl_regs[127:96]), 64'(ctrl_m[3]));
      model_write(3, 32'h0BAD_F00D, 4'hF);
      tick();
      check_val("b2_valid", 64'(S_AXI_BVALID), 64'd1);
      check_val("ctrl3_commit", 64'(ctrl_regs[127:96]), 64'(ctrl_m[3]));
      check_val("ctrl1_commit", 64'(ctrl_regs[63:32]), 64'(ctrl_m[1]));
      tick();

      // reset while a write is held and B/R are pending
      S_AXI_BREADY = 1'b0;
      S_AXI_RREADY = 1'b0;
      drive_aw_w(0, 32'h7777_7777, 4'hF);
      tick();
      drive_aw_w(1, 32'h5555_5555, 4'hF);
      S_AXI_ARADDR  = AW'(2 * 4);
      S_AXI_ARVALID = 1'b1;
      tick();
      S_AXI_ARVALID = 1'b0;
      S_AXI_ARESETN = 1'b0;
      model_reset();
      #2;
      check_reset_outputs("midreset");
      tick();
      tick();
      S_AXI_ARESETN = 1'b1;
      S_AXI_BREADY  = 1'b1;
      S_AXI_RREADY  = 1'b1;
      tick();
      tick();
      check_val("no_commit_b", 64'(S_AXI_BVALID), 64'd0);
      check_val("no_commit_ctrl1", 64'(ctrl_regs[63:32]), 64'(ctrl_m[1]));
      axi_read(1);

      repeat (3) tick();
      check_val("b_queue_empty", 64'(exp_b_q.size()), 64'd0);
      check_val("r_queue_empty", 64'(exp_r_q.size()), 64'd0);

      // report
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
